l2r_modexp: RTL

L2R_MODEXP -- requirements
Module: l2r_modexp

---
 rtl/l2r_modexp_if.sv | 24 ++
 rtl/l2r_modexp.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/l2r_modexp_if.sv
// Request/response bundle for the left-to-right modular exponentiator.
// The master drives operands and start; the slave returns result and status.
interface l2r_modexp_if #(
    parameter int K = 16
);
    logic         start;
    logic [K-1:0] A;
    logic [K-1:0] B;
    logic [K-1:0] M;
    logic [K-1:0] C;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output start, A, B, M,
        input  C, busy, done, err
    );

    modport slave (
        input  start, A, B, M,
        output C, busy, done, err
    );
endinterface

// File: rtl/l2r_modexp.sv
// Computes C = A^B mod M with MSB-first square-and-multiply over all K exponent
// bits; every modular product is an interleaved shift-add taking K cycles.
module l2r_modexp #(
    parameter int K = 16
) (
    input logic          clk,
    input logic          rst,
    l2r_modexp_if.slave  bus
);
    localparam int            CW   = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR,
        MUL,
        FIN
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [K-1:0]  a_q;
    logic [K-1:0]  b_q;
    logic [K-1:0]  m_q;
    logic [K-1:0]  r_q;
    logic [K-1:0]  p_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] ebit_q;
    logic [K-1:0]  c_q;
    logic          err_q;

    logic [K+1:0]  m1;
    logic [K+1:0]  m2;
    logic [K+1:0]  t;
    logic [K+1:0]  sub;
    logic [K-1:0]  y;
    logic [K-1:0]  red;
    logic          xb;
    logic          mul_last;
    logic          illegal;

    // One shift-add step: P < M keeps 2P + Y below 3M, so at most one
    // subtraction of 2M or M brings it back into [0, M-1].
    always_comb begin
        y   = (state == MUL) ? a_q : r_q;
        xb  = r_q[LAST - cnt_q];
        m1  = {2'b00, m_q};
        m2  = {1'b0, m_q, 1'b0};
        t   = {1'b0, p_q, 1'b0} + {2'b00, y & {K{xb}}};
        sub = '0;
        if (t >= m2) begin
            sub = m2;
        end else if (t >= m1) begin
            sub = m1;
        end
        red = K'(t - sub);
    end

    assign mul_last = (cnt_q == LAST);
    assign illegal  = (m_q == '0) || (a_q >= m_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                state_nx = illegal ? FIN : SQR;
            end
            SQR: begin
                if (mul_last) begin
                    if (b_q[ebit_q]) begin
                        state_nx = MUL;
                    end else if (ebit_q == '0) begin
                        state_nx = FIN;
                    end
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_nx = (ebit_q == '0) ? FIN : SQR;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            r_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            ebit_q <= '0;
            c_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q <= bus.A;
                        b_q <= bus.B;
                        m_q <= bus.M;
                    end
                end
                LOAD: begin
                    r_q    <= (m_q == K'(1)) ? '0 : K'(1);
                    p_q    <= '0;
                    cnt_q  <= '0;
                    ebit_q <= LAST;
                    if (illegal) begin
                        c_q   <= '0;
                        err_q <= 1'b1;
                    end
                end
                SQR, MUL: begin
                    if (mul_last) begin
                        r_q   <= red;
                        p_q   <= '0;
                        cnt_q <= '0;
                        if (state_nx == SQR) begin
                            ebit_q <= ebit_q - 1'b1;
                        end
                        if (state_nx == FIN) begin
                            c_q   <= red;
                            err_q <= 1'b0;
                        end
                    end else begin
                        p_q   <= red;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.C    = c_q;
    assign bus.err  = err_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == FIN);
endmodule
